// File: rtl/lcm_reg_bank_if.sv
// Host register-write bus into the LCM register bank; write accepted every cycle,
// ack/err returned one cycle later, no backpressure on wr_en.
interface lcm_reg_bank_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_err;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  wr_ack, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output wr_ack, wr_err
    );
endinterface

// File: rtl/lcm_reg_bank.sv
// LCM register bank: decodes host writes into send config, control pulses and a send-run FSM.
// Latency: register/ack one cycle after the write; writes are never back-pressured (rejects flagged via wr_err).
module lcm_reg_bank #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 64,
    parameter int PULSE_LEN = 4,
    parameter int RD_ADDR_W = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    lcm_reg_bank_if.slave                 wr,
    input  logic                          pkt_sent,
    output logic                          lcm2ssm_reset,
    output logic                          pgm_config_reset,
    output logic                          lcm2ssm_rd,
    output logic [RD_ADDR_W-1:0]          lcm2ssm_addr,
    output logic [7:0]                    protocol_type,
    output logic                          sent_model,
    output logic [DATA_W-1:0]             sent_time_reg_o,
    output logic [DATA_W-1:0]             sent_num_reg_o,
    output logic [NUM_PORTS*DATA_W-1:0]   sent_start_time_n_reg_o,
    output logic [NUM_PORTS*DATA_W-1:0]   sent_rate_n_reg_o,
    output logic                          sent_start,
    output logic                          sent_done
);
    localparam int PW = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] run_cnt, run_inc, run_nxt, target;
    logic [PW-1:0]     ssm_cnt, pgm_cnt;
    logic [DATA_W-1:0] start_q [NUM_PORTS];
    logic [DATA_W-1:0] rate_q  [NUM_PORTS];

    logic [31:0] addr_i;
    logic is_ctrl, is_proto, is_model, is_time, is_num, is_rd, is_port, addr_ok;
    logic ctrl_wr, ctrl_start, start_rej, lock_rej, wr_rej, wr_acc, start_go, abort;

    // Write decode and accept/reject classification
    always_comb begin
        addr_i     = 32'(wr.wr_addr);
        is_ctrl    = (addr_i == 32'd0);
        is_proto   = (addr_i == 32'd1);
        is_model   = (addr_i == 32'd2);
        is_time    = (addr_i == 32'd3);
        is_num     = (addr_i == 32'd4);
        is_rd      = (addr_i == 32'd5);
        is_port    = (addr_i >= 32'd16) && (addr_i < 32'(16 + 2 * NUM_PORTS));
        addr_ok    = is_ctrl | is_proto | is_model | is_time | is_num | is_rd | is_port;
        target     = sent_model ? sent_time_reg_o : sent_num_reg_o;
        ctrl_wr    = wr.wr_en && is_ctrl;
        // stop beats start when both bits are set in one CTRL write
        ctrl_start = is_ctrl && wr.wr_data[2] && !wr.wr_data[3];
        start_rej  = ctrl_start && ((state_q != IDLE) || (target == '0));
        lock_rej   = (state_q == RUN) && (is_model | is_time | is_num | is_port);
        wr_rej     = !addr_ok || lock_rej || start_rej;
        wr_acc     = wr.wr_en && !wr_rej;
        start_go   = wr.wr_en && ctrl_start && !start_rej;
        abort      = ctrl_wr && (wr.wr_data[3] || wr.wr_data[0]);
        run_inc    = sent_model ? DATA_W'(1) : DATA_W'(pkt_sent);
        run_nxt    = run_cnt + run_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = RUN;
            RUN: begin
                if (abort)                  state_d = IDLE;
                else if (run_nxt == target) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sent_start = (state_q == RUN);
        sent_done  = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (state_q != RUN && state_d == RUN) begin
            run_cnt <= '0;
        end else if (state_q == RUN) begin
            run_cnt <= run_nxt;
        end
    end

    // Pulse counters: any trigger reloads, so a re-trigger stretches the pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssm_cnt <= '0;
            pgm_cnt <= '0;
        end else begin
            if (ctrl_wr && wr.wr_data[0]) ssm_cnt <= PW'(PULSE_LEN);
            else if (ssm_cnt != '0)       ssm_cnt <= ssm_cnt - PW'(1);
            if (ctrl_wr && wr.wr_data[1]) pgm_cnt <= PW'(PULSE_LEN);
            else if (pgm_cnt != '0)       pgm_cnt <= pgm_cnt - PW'(1);
        end
    end

    assign lcm2ssm_reset    = (ssm_cnt != '0);
    assign pgm_config_reset = (pgm_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr.wr_ack       <= 1'b0;
            wr.wr_err       <= 1'b0;
            lcm2ssm_rd      <= 1'b0;
            lcm2ssm_addr    <= '0;
            protocol_type   <= '0;
            sent_model      <= 1'b0;
            sent_time_reg_o <= '0;
            sent_num_reg_o  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                start_q[p] <= '0;
                rate_q[p]  <= '0;
            end
        end else begin
            wr.wr_ack  <= wr.wr_en;
            wr.wr_err  <= wr.wr_en && wr_rej;
            lcm2ssm_rd <= wr_acc && is_rd;
            if (wr_acc) begin
                if (is_proto) protocol_type   <= wr.wr_data[7:0];
                if (is_model) sent_model      <= wr.wr_data[0];
                if (is_time)  sent_time_reg_o <= wr.wr_data;
                if (is_num)   sent_num_reg_o  <= wr.wr_data;
                if (is_rd)    lcm2ssm_addr    <= wr.wr_data[RD_ADDR_W-1:0];
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (addr_i == 32'(16 + 2 * p)) start_q[p] <= wr.wr_data;
                    if (addr_i == 32'(17 + 2 * p)) rate_q[p]  <= wr.wr_data;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pack
        assign sent_start_time_n_reg_o[p*DATA_W +: DATA_W] = start_q[p];
        assign sent_rate_n_reg_o[p*DATA_W +: DATA_W]       = rate_q[p];
    end
endmodule

// File: tb/tb_lcm_reg_bank.sv
// Directed-vector bench for lcm_reg_bank with hand-computed expectations.
module tb_lcm_reg_bank;
    logic         clk = 1'b0;
    logic         rst;
    logic         pkt_sent;
    logic         lcm2ssm_reset, pgm_config_reset, lcm2ssm_rd;
    logic [10:0]  lcm2ssm_addr;
    logic [7:0]   protocol_type;
    logic         sent_model;
    logic [63:0]  sent_time_reg_o, sent_num_reg_o;
    logic [255:0] sent_start_time_n_reg_o, sent_rate_n_reg_o;
    logic         sent_start, sent_done;

    int n_vec = 0;
    int n_err = 0;

    lcm_reg_bank_if #(.ADDR_W(8), .DATA_W(64)) bus ();

    lcm_reg_bank #(
        .NUM_PORTS(4), .ADDR_W(8), .DATA_W(64), .PULSE_LEN(4), .RD_ADDR_W(11)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .wr                      (bus.slave),
        .pkt_sent                (pkt_sent),
        .lcm2ssm_reset           (lcm2ssm_reset),
        .pgm_config_reset        (pgm_config_reset),
        .lcm2ssm_rd              (lcm2ssm_rd),
        .lcm2ssm_addr            (lcm2ssm_addr),
        .protocol_type           (protocol_type),
        .sent_model              (sent_model),
        .sent_time_reg_o         (sent_time_reg_o),
        .sent_num_reg_o          (sent_num_reg_o),
        .sent_start_time_n_reg_o (sent_start_time_n_reg_o),
        .sent_rate_n_reg_o       (sent_rate_n_reg_o),
        .sent_start              (sent_start),
        .sent_done               (sent_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one write for one cycle; returns just after the capturing edge
    task automatic wr(input logic [7:0] a, input logic [63:0] d, input logic exp_err);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        check("wr_ack", 64'(bus.wr_ack), 64'd1);
        check("wr_err", 64'(bus.wr_err), 64'(exp_err));
    endtask

    initial begin
        int hi, dn, done_at;
        rst = 1'b1; pkt_sent = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 64'(sent_start), 64'd0);
        check("rst_done", 64'(sent_done), 64'd0);
        check("rst_ssm", 64'(lcm2ssm_reset), 64'd0);
        check("rst_pgm", 64'(pgm_config_reset), 64'd0);
        check("rst_rd", 64'(lcm2ssm_rd), 64'd0);
        check("rst_proto", 64'(protocol_type), 64'd0);
        check("rst_num", sent_num_reg_o, 64'd0);
        check("rst_ack", 64'(bus.wr_ack), 64'd0);
        check("rst_ports", 64'(sent_start_time_n_reg_o != '0 || sent_rate_n_reg_o != '0), 64'd0);
        rst = 1'b0;
        tick();
        wr(8'h01, 64'hA5, 1'b0);
        check("proto", 64'(protocol_type), 64'hA5);
        tick();
        check("ack_idle", 64'(bus.wr_ack), 64'd0);

        // Map sweep
        for (int i = 0; i < 8; i++) wr(8'(16 + i), 64'(i), 1'b0);
        for (int p = 0; p < 4; p++) begin
            check("start_time_p", sent_start_time_n_reg_o[p*64 +: 64], 64'(2 * p));
            check("rate_p", sent_rate_n_reg_o[p*64 +: 64], 64'(2 * p + 1));
        end
        wr(8'h18, 64'h55, 1'b1);
        wr(8'h06, 64'h55, 1'b1);
        check("start_time_p3_kept", sent_start_time_n_reg_o[192 +: 64], 64'd6);

        // SSM reset pulse re-triggered two cycles later: 6 cycles high
        wr(8'h00, 64'h1, 1'b0);
        hi = int'(lcm2ssm_reset);
        tick();
        hi += int'(lcm2ssm_reset);
        wr(8'h00, 64'h1, 1'b0);
        hi += int'(lcm2ssm_reset);
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(lcm2ssm_reset);
        end
        check("ssm_rst_len", 64'(hi), 64'd6);
        wr(8'h00, 64'h2, 1'b0);
        hi = int'(pgm_config_reset);
        for (int i = 0; i < 10; i++) begin
            tick();
            hi += int'(pgm_config_reset);
        end
        check("pgm_rst_len", 64'(hi), 64'd4);
        wr(8'h05, 64'h7FF, 1'b0);
        check("rd_pulse", 64'(lcm2ssm_rd), 64'd1);
        check("rd_addr", 64'(lcm2ssm_addr), 64'h7FF);
        tick();
        check("rd_low", 64'(lcm2ssm_rd), 64'd0);
        check("rd_addr_hold", 64'(lcm2ssm_addr), 64'h7FF);

        // Count-mode run
        wr(8'h04, 64'd3, 1'b0);
        wr(8'h02, 64'd0, 1'b0);
        wr(8'h00, 64'h4, 1'b0);
        check("cnt_start", 64'(sent_start), 64'd1);
        for (int k = 0; k < 3; k++) begin
            pkt_sent = 1'b1;
            tick();
            pkt_sent = 1'b0;
            if (k < 2) begin
                check("cnt_running", 64'(sent_start), 64'd1);
                check("cnt_no_done", 64'(sent_done), 64'd0);
                tick();
            end
        end
        check("cnt_done", 64'(sent_done), 64'd1);
        check("cnt_start_off", 64'(sent_start), 64'd0);
        tick();
        check("cnt_done_1cyc", 64'(sent_done), 64'd0);
        check("cnt_idle", 64'(sent_start), 64'd0);

        // Time-mode run of 10 cycles
        wr(8'h03, 64'd10, 1'b0);
        wr(8'h02, 64'd1, 1'b0);
        wr(8'h00, 64'h4, 1'b0);
        hi = int'(sent_start); dn = 0; done_at = -1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            hi += int'(sent_start);
            dn += int'(sent_done);
            if (sent_done && done_at < 0) done_at = i;
        end
        check("time_start_len", 64'(hi), 64'd10);
        check("time_done_cnt", 64'(dn), 64'd1);
        check("time_done_at", 64'(done_at), 64'd10);

        // Zero target start rejected
        wr(8'h02, 64'd0, 1'b0);
        wr(8'h04, 64'd0, 1'b1 ^ 1'b1);
        wr(8'h00, 64'h4, 1'b1);
        check("zero_tgt_idle", 64'(sent_start), 64'd0);

        // Locks in RUN, start in RUN, stop coinciding with final packet
        wr(8'h04, 64'd2, 1'b0);
        wr(8'h00, 64'h4, 1'b0);
        wr(8'h03, 64'h99, 1'b1);
        check("time_locked", sent_time_reg_o, 64'd10);
        wr(8'h10, 64'h77, 1'b1);
        check("port_locked", sent_start_time_n_reg_o[0 +: 64], 64'd0);
        wr(8'h00, 64'h4, 1'b1);
        check("run_unaffected", 64'(sent_start), 64'd1);
        wr(8'h01, 64'h3C, 1'b0);
        check("proto_in_run", 64'(protocol_type), 64'h3C);
        pkt_sent = 1'b1;
        tick();
        pkt_sent = 1'b0;
        check("one_pkt_run", 64'(sent_start), 64'd1);
        pkt_sent = 1'b1;
        wr(8'h00, 64'h8, 1'b0);
        pkt_sent = 1'b0;
        check("stop_wins_done", 64'(sent_done), 64'd0);
        check("stop_wins_idle", 64'(sent_start), 64'd0);
        tick();
        check("stop_no_late_done", 64'(sent_done), 64'd0);

        // start+stop together: stop wins; ssm_reset aborts a run
        wr(8'h00, 64'hC, 1'b0);
        check("start_stop", 64'(sent_start), 64'd0);
        wr(8'h00, 64'h4, 1'b0);
        wr(8'h00, 64'h1, 1'b0);
        check("abort_idle", 64'(sent_start), 64'd0);
        check("abort_pulse", 64'(lcm2ssm_reset), 64'd1);
        tick();
        check("abort_no_done", 64'(sent_done), 64'd0);

        // Async reset mid-run
        wr(8'h00, 64'h4, 1'b0);
        check("pre_rst_run", 64'(sent_start), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_start", 64'(sent_start), 64'd0);
        check("async_rst_num", sent_num_reg_o, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
